opll_write_sequencer: RTL
=========================

Name: opll_write_sequencer

Overview:
- Buffers host register writes (address, data) and replays each one onto the IKAOPLL bus pins (i_D, i_A0, i_WR_n, i_CS_n).
- Enforces the YM2413 address-to-data and data-to-next-address wait times, counted in clk cycles. phiM runs at clk because i_phiM_PCEN_n is tied 0.
- Sits between the tile's host-facing write port and the IKAOPLL instance, so hosts never track chip timing.

Parameters:
- FIFO_DEPTH, 4: number of queued write pairs; power of two, 2..16.
- WR_PULSE, 2: clk cycles o_WR_n is held low per strobe; 1..15.
- ADDR_WAIT, 12: clk cycles of idle bus after the address strobe, before the data strobe; 1..255.
- DATA_WAIT, 84: clk cycles of idle bus after the data strobe, before the next address strobe; 1..255.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- i_req_valid, input, 1: host offers a write pair.
- o_req_ready, output, 1: FIFO can accept a pair.
- i_req_addr, input, 8: OPLL register address.
- i_req_data, input, 8: OPLL register data.
- o_D, output, 8: bus data to the IKAOPLL i_D pin.
- o_A0, output, 1: 0 = address phase, 1 = data phase.
- o_WR_n, output, 1: write strobe, active low.
- o_CS_n, output, 1: chip select, active low; low only during strobes.
- o_busy, output, 1: FIFO not empty, or state is not IDLE.
- o_fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.

Behaviour:
- Reset and outputs:
  - rst has priority over everything.
  - In the cycle after rst is sampled high: state = IDLE, FIFO emptied, counter = 0.
  - Reset output values: o_D=0, o_A0=0, o_WR_n=1, o_CS_n=1, o_busy=0, o_fifo_count=0, o_req_ready=1.
  - Reset mid-write aborts immediately. A truncated strobe is acceptable.
  - All bus outputs are registered.
- Handshake:
  - A push occurs on an edge where i_req_valid && o_req_ready.
  - o_req_ready = !full, combinational from the count.
  - Full: no push, and no pass-through even if a pop occurs in the same cycle.
  - Simultaneous push and pop: count unchanged.
- FSM states: IDLE, ADDR_STB, ADDR_GAP, DATA_STB, DATA_GAP.
  - IDLE: if the FIFO is not empty, pop the head into holding registers (addr, data) and go to ADDR_STB. Otherwise stay; outputs o_WR_n=1, o_CS_n=1, o_D and o_A0 hold their last values.
  - ADDR_STB: o_D=addr, o_A0=0, o_WR_n=0, o_CS_n=0 for exactly WR_PULSE cycles, then ADDR_GAP.
  - ADDR_GAP: o_WR_n=1, o_CS_n=1, o_D and o_A0 held, for exactly ADDR_WAIT cycles, then DATA_STB.
  - DATA_STB: o_D=data, o_A0=1, o_WR_n=0, o_CS_n=0 for exactly WR_PULSE cycles, then DATA_GAP.
  - DATA_GAP: strobe and select high for exactly DATA_WAIT cycles.
    - FIFO not empty: pop and go directly to ADDR_STB, with no IDLE cycle.
    - FIFO empty: go to IDLE.
- Latency and throughput:
  - Push at edge N into an empty FIFO with state IDLE: o_WR_n is first low in cycle N+2.
  - Back-to-back throughput is one pair per 2*WR_PULSE + ADDR_WAIT + DATA_WAIT cycles (100 at defaults).
- Counter: one down-counter of width 8, loaded on each state entry with (phase length - 1). The state advances when the counter is 0.
- FIFO: pointers wrap modulo FIFO_DEPTH. The count saturates at neither end, because push is blocked when full and pop is blocked when empty.

Optional Feature:
- Macro: OPLL_SEQ_ADDR_CACHE_EN.
- When defined:
  - A valid bit and an 8-bit last-address register are updated on each ADDR_STB entry.
  - If the popped addr equals the cached address and the valid bit is set, skip ADDR_STB and ADDR_GAP and enter DATA_STB directly. The chip's address latch retains the address.
  - rst clears the valid bit.
  - A throughput counter is not required.
- When undefined: every pair gets a full address phase, and the cache logic is absent.

Decomposition:
- Package opll_seq_pkg:
  - state enum (IDLE, ADDR_STB, ADDR_GAP, DATA_STB, DATA_GAP);
  - default timing localparams (WR_PULSE_DEF=2, ADDR_WAIT_DEF=12, DATA_WAIT_DEF=84);
  - 16-bit write-pair struct {addr, data}.
- Sub-module opll_seq_fifo: synchronous FIFO parameterised by depth and width, with push/pop/full/empty/count ports. The FSM, counter and bus registers live in the top.

Test Plan:
- Reset: hold rst for 3 cycles mid-DATA_STB.
  - Next cycle: o_WR_n=1, o_CS_n=1, o_D=0, o_A0=0, o_fifo_count=0.
  - No further strobes.
- Single write: push (0x10, 0x5A) at edge N.
  - o_WR_n low in cycles N+2..N+3 with o_D=0x10, o_A0=0.
  - High for 12 cycles.
  - Low in cycles N+16..N+17 with o_D=0x5A, o_A0=1.
  - o_busy drops at N+102.
- Back-to-back: push 3 pairs in consecutive cycles.
  - Consecutive address strobes start exactly 100 cycles apart.
  - There is no IDLE cycle between pairs.
- Full FIFO: push 6 pairs with the sink stalled in gaps.
  - o_req_ready=0 when o_fifo_count=4.
  - Extra pushes are dropped.
  - Push and pop in the same cycle keeps the count constant.
- Parameter sweep: WR_PULSE=1, ADDR_WAIT=1, DATA_WAIT=1.
  - Period is 4 cycles per pair.
  - Strobe widths are exactly 1 cycle.
- With OPLL_SEQ_ADDR_CACHE_EN: pairs (0x20,0x01) then (0x20,0x02).
  - The second pair produces only a data strobe, 86 cycles after the first data strobe.
  - After reset, the same address again produces an address strobe.

Source files
------------

// File: rtl/opll_seq_pkg.sv
// Shared types and default timing for the OPLL write sequencer.
//
// Contents:
//   seq_state_e   - bus sequencing states
//   *_DEF         - default strobe width and wait times, in clk cycles
//   wr_pair_t     - one buffered host write (register address + data)
package opll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_STB,
    ADDR_GAP,
    DATA_STB,
    DATA_GAP
  } seq_state_e;

  localparam int WR_PULSE_DEF  = 2;
  localparam int ADDR_WAIT_DEF = 12;
  localparam int DATA_WAIT_DEF = 84;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_pair_t;

endpackage

// File: rtl/opll_write_sequencer_if.sv
// Host write port plus IKAOPLL bus pins of the OPLL write sequencer.
//
// Signals:
//   i_req_valid/o_req_ready/i_req_addr/i_req_data - host write handshake
//   o_D/o_A0/o_WR_n/o_CS_n                         - IKAOPLL bus pins
//   o_busy/o_fifo_count                            - status
// Modports:
//   master - host side (drives requests, observes everything else)
//   slave  - the sequencer itself
interface opll_write_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          i_req_valid;
  logic                          o_req_ready;
  logic [7:0]                    i_req_addr;
  logic [7:0]                    i_req_data;
  logic [7:0]                    o_D;
  logic                          o_A0;
  logic                          o_WR_n;
  logic                          o_CS_n;
  logic                          o_busy;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;

  modport master (
    output i_req_valid, i_req_addr, i_req_data,
    input  o_req_ready, o_D, o_A0, o_WR_n, o_CS_n, o_busy, o_fifo_count
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_data,
    output o_req_ready, o_D, o_A0, o_WR_n, o_CS_n, o_busy, o_fifo_count
  );
endinterface

// File: rtl/opll_seq_fifo.sv
// Small synchronous FIFO holding pending write pairs.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   push_i    - write wdata_i (ignored when full)
//   wdata_i   - entry to store
//   pop_i     - drop the head entry (ignored when empty)
//   rdata_o   - head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o - occupancy status
module opll_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage needs no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/opll_write_sequencer.sv
// Buffers host register writes and replays each as an address strobe followed
// by a data strobe on the IKAOPLL bus, inserting the YM2413 wait times.
//
// Ports:
//   clk  - single clock (phiM runs at clk)
//   rst  - synchronous active-high reset, aborts any write in flight
//   bus  - opll_write_sequencer_if.slave: host handshake, bus pins, status
//
// Optional feature (macro OPLL_SEQ_ADDR_CACHE_EN): remember the last address
// driven to the chip and skip the address phase when the next pair reuses it.
module opll_write_sequencer
  import opll_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_PULSE   = WR_PULSE_DEF,
  parameter int ADDR_WAIT  = ADDR_WAIT_DEF,
  parameter int DATA_WAIT  = DATA_WAIT_DEF
) (
  input logic                   clk,
  input logic                   rst,
  opll_write_sequencer_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] STB_LOAD  = 8'(WR_PULSE - 1);
  localparam logic [7:0] ADDR_LOAD = 8'(ADDR_WAIT - 1);
  localparam logic [7:0] DATA_LOAD = 8'(DATA_WAIT - 1);

  seq_state_e    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    d_q;
  logic          a0_q, wr_n_q, cs_n_q, busy_q;
  wr_pair_t      push_pair, head_pair;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          start_pair;
  logic          hit;

  assign push_pair = '{addr: bus.i_req_addr, data: bus.i_req_data};
  assign fifo_push = bus.i_req_valid && !fifo_full;

  opll_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_pair_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (push_pair),
    .pop_i   (fifo_pop),
    .rdata_o (head_pair),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef OPLL_SEQ_ADDR_CACHE_EN
  logic       cache_vld_q, cache_vld_d;
  logic [7:0] cache_addr_q, cache_addr_d;

  assign hit = cache_vld_q && (head_pair.addr == cache_addr_q);

  // The chip's address latch still holds whatever the last ADDR_STB drove.
  always_comb begin
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    if (start_pair && !hit) begin
      cache_vld_d  = 1'b1;
      cache_addr_d = head_pair.addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Next state: each phase loads the counter with (length - 1) on entry and
  // advances once it reaches zero. A pair is popped either from IDLE or at the
  // end of DATA_GAP, so back-to-back pairs never pass through IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    start_pair = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) start_pair = 1'b1;
      end
      ADDR_STB: begin
        if (cnt_q == '0) begin
          state_d = ADDR_GAP;
          cnt_d   = ADDR_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ADDR_GAP: begin
        if (cnt_q == '0) begin
          state_d = DATA_STB;
          cnt_d   = STB_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DATA_STB: begin
        if (cnt_q == '0) begin
          state_d = DATA_GAP;
          cnt_d   = DATA_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DATA_GAP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) start_pair = 1'b1;
          else             state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_pair) begin
      addr_d  = head_pair.addr;
      data_d  = head_pair.data;
      cnt_d   = STB_LOAD;
      state_d = hit ? DATA_STB : ADDR_STB;
    end
  end

  assign fifo_pop = start_pair;

  // State, phase counter and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Bus pins are registered from the current state, so they trail the state
  // by one cycle; D and A0 keep their last value outside strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      a0_q   <= 1'b0;
      wr_n_q <= 1'b1;
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      busy_q <= !fifo_empty || (state_q != IDLE);
      wr_n_q <= 1'b1;
      cs_n_q <= 1'b1;
      case (state_q)
        ADDR_STB: begin
          d_q    <= addr_q;
          a0_q   <= 1'b0;
          wr_n_q <= 1'b0;
          cs_n_q <= 1'b0;
        end
        DATA_STB: begin
          d_q    <= data_q;
          a0_q   <= 1'b1;
          wr_n_q <= 1'b0;
          cs_n_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_req_ready  = !fifo_full;
  assign bus.o_fifo_count = fifo_count;
  assign bus.o_D          = d_q;
  assign bus.o_A0         = a0_q;
  assign bus.o_WR_n       = wr_n_q;
  assign bus.o_CS_n       = cs_n_q;
  assign bus.o_busy       = busy_q;

endmodule
